seq_alu_adder: RTL

- Parametrised multi-cycle add/subtract unit for the LEGv8 datapath.
- Processes operands CHUNK bits per cycle, lowest chunk first, carrying between chunks through a registered carry.
- Produces a WIDTH-bit result plus the NZCV condition flags used by ADDS/SUBS and CBZ/B.cond.
- Sits beside the ALU and PC logic and uses a start/busy/done handshake, so long adds do not set the single-cycle critical path.

---
 rtl/arm_pkg.sv | 19 +
 rtl/seq_alu_adder_chunk_adder.sv | 17 +
 rtl/seq_alu_adder.sv | 139 +++++++++++++
 3 files changed

// File: rtl/arm_pkg.sv
// Shared LEGv8 datapath definitions: word width, NZCV flag bit positions, sequential adder FSM states.
// Latency: none (declarations only).
// Backpressure: not applicable.
package arm_pkg;

    localparam int WORD   = 64;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_add_state_t;

endpackage

// File: rtl/seq_alu_adder_chunk_adder.sv
// W-bit ripple slice of the sequential adder: sum and carry out from two operands plus carry in.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is captured.
module chunk_adder #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    // One extra bit on each operand captures the carry out of the slice.
    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/seq_alu_adder.sv
// Multi-cycle add/subtract with NZCV flags, CHUNK bits per cycle, lowest chunk first.
// Latency: WIDTH/CHUNK cycles in RUN; done pulses in the cycle after the last chunk edge.
// Backpressure: start is accepted only while ready (IDLE or DONE); start during RUN is ignored.
module seq_alu_adder
    import arm_pkg::*;
#(
    parameter int WIDTH = WORD,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] add_out,
    output logic [3:0]       flags
);

    localparam int NCHUNK = WIDTH / CHUNK;
    // Keep the chunk index at least one bit wide so CHUNK == WIDTH still elaborates.
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [WIDTH-1:0] SLICE_MASK = WIDTH'({CHUNK{1'b1}});
    localparam logic [KW-1:0]    K_LAST     = KW'(NCHUNK - 1);

    seq_add_state_t   state_q,   state_d;
    logic [WIDTH-1:0] opa_q,     opa_d;
    logic [WIDTH-1:0] opb_q,     opb_d;
    logic             carry_q,   carry_d;
    logic [KW-1:0]    k_q,       k_d;
    logic [WIDTH-1:0] part_q,    part_d;
    logic [WIDTH-1:0] add_out_q, add_out_d;
    logic [3:0]       flags_q,   flags_d;

    logic [31:0]      base;
    logic [WIDTH-1:0] opa_sh;
    logic [WIDTH-1:0] opb_sh;
    logic [CHUNK-1:0] a_slice;
    logic [CHUNK-1:0] b_slice;
    logic [CHUNK-1:0] s_slice;
    logic             c_out;
    logic [WIDTH-1:0] part_next;

    // Select slice k of each operand by shifting it down to bit 0.
    assign base    = 32'(k_q) * 32'(CHUNK);
    assign opa_sh  = opa_q >> base;
    assign opb_sh  = opb_q >> base;
    assign a_slice = opa_sh[CHUNK-1:0];
    assign b_slice = opb_sh[CHUNK-1:0];

    chunk_adder #(
        .W    (CHUNK)
    ) u_chunk_adder (
        .a    (a_slice),
        .b    (b_slice),
        .cin  (carry_q),
        .sum  (s_slice),
        .cout (c_out)
    );

    // Partial result with slice k replaced by this cycle's sum; on the last chunk this is the full result.
    assign part_next = (part_q & ~(SLICE_MASK << base)) | (WIDTH'(s_slice) << base);

    // Next-state, operand capture and result/flag update.
    always_comb begin
        state_d   = state_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        carry_d   = carry_q;
        k_d       = k_q;
        part_d    = part_q;
        add_out_d = add_out_q;
        flags_d   = flags_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    // Subtraction is a + ~b + 1: invert B here and seed the carry with 1.
                    opa_d   = a_in;
                    opb_d   = sub ? ~b_in : b_in;
                    carry_d = sub;
                    k_d     = '0;
                    state_d = RUN;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                part_d  = part_next;
                carry_d = c_out;
                k_d     = k_q + 1'b1;
                if (k_q == K_LAST) begin
                    // Result and flags become visible together on the edge into DONE.
                    add_out_d        = part_next;
                    flags_d[FLAG_N]  = part_next[WIDTH-1];
                    flags_d[FLAG_Z]  = (part_next == '0);
                    flags_d[FLAG_C]  = c_out;
                    flags_d[FLAG_V]  = (opa_q[WIDTH-1] == opb_q[WIDTH-1]) &&
                                       (part_next[WIDTH-1] != opa_q[WIDTH-1]);
                    state_d          = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            opa_q     <= '0;
            opb_q     <= '0;
            carry_q   <= 1'b0;
            k_q       <= '0;
            part_q    <= '0;
            add_out_q <= '0;
            flags_q   <= 4'b0000;
        end else begin
            state_q   <= state_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            carry_q   <= carry_d;
            k_q       <= k_d;
            part_q    <= part_d;
            add_out_q <= add_out_d;
            flags_q   <= flags_d;
        end
    end

    assign ready   = (state_q != RUN);
    assign busy    = (state_q == RUN);
    assign done    = (state_q == DONE);
    assign add_out = add_out_q;
    assign flags   = flags_q;

endmodule
